// File: rtl/tt_fpga_pad_bridge.sv
`default_nettype none
// tt_fpga_pad_bridge: pad-side input synchronisers, registered bidir drive and a
// hold-window reset conditioner between the iCE40 SB_IO cells and a Tiny Tapeout core.
module tt_fpga_pad_bridge #(
  parameter int UI_WIDTH        = 8,
  parameter int UIO_WIDTH       = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [UI_WIDTH-1:0]  ui_pad_in,
  output logic [UI_WIDTH-1:0]  ui_in,
  input  logic [UIO_WIDTH-1:0] uio_pad_in,
  output logic [UIO_WIDTH-1:0] uio_pad_out,
  output logic [UIO_WIDTH-1:0] uio_pad_oe,
  output logic [UIO_WIDTH-1:0] uio_in,
  input  logic [UIO_WIDTH-1:0] uio_out,
  input  logic [UIO_WIDTH-1:0] uio_oe,
  output logic                 core_rst_n,
  output logic                 core_ena
);

  localparam int CNT_W = $clog2(RST_HOLD_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     hold_cnt;
  logic [1:0]           rst_sync;
  logic                 rst_s;
  logic [UI_WIDTH-1:0]  ui_sync  [SYNC_STAGES];
  logic [UIO_WIDTH-1:0] uio_sync [SYNC_STAGES];

  // Independent flop chains per bit; uio is sampled even while the core drives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        ui_sync[i]  <= '0;
        uio_sync[i] <= '0;
      end
    end else begin
      ui_sync[0]  <= ui_pad_in;
      uio_sync[0] <= uio_pad_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ui_sync[i]  <= ui_sync[i-1];
        uio_sync[i] <= uio_sync[i-1];
      end
    end
  end

  assign ui_in  = ui_sync[SYNC_STAGES-1];
  assign uio_in = uio_sync[SYNC_STAGES-1];

  // Async assert, sync deassert of the board reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_s = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RESET;
      hold_cnt   <= '0;
      core_rst_n <= 1'b0;
      core_ena   <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          core_rst_n <= 1'b0;
          core_ena   <= 1'b0;
          if (rst_s) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == CNT_LAST) begin
            state      <= ST_RUN;
            core_rst_n <= 1'b1;
            core_ena   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + CNT_ONE;
          end
        end
        ST_RUN: begin
          core_rst_n <= 1'b1;
          core_ena   <= 1'b1;
        end
        default: begin
          state      <= ST_RESET;
          hold_cnt   <= '0;
          core_rst_n <= 1'b0;
          core_ena   <= 1'b0;
        end
      endcase
    end
  end

  // Pads stay hi-Z until the core is running; drive data is passed through regardless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uio_pad_out <= '0;
      uio_pad_oe  <= '0;
    end else begin
      uio_pad_out <= uio_out;
      uio_pad_oe  <= (state == ST_RUN) ? uio_oe : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_fpga_pad_bridge.sv
`default_nettype none
// Randomised self-checking bench for tt_fpga_pad_bridge against an edge-counting model.
module tb_tt_fpga_pad_bridge;

  localparam int SYNC = 2;
  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_pad_in, ui_in, uio_pad_in, uio_pad_out, uio_pad_oe, uio_in, uio_out, uio_oe;
  logic       core_rst_n, core_ena;

  int total = 0;
  int bad   = 0;

  tt_fpga_pad_bridge #(
    .UI_WIDTH(8), .UIO_WIDTH(8), .SYNC_STAGES(SYNC), .RST_HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ui_pad_in(ui_pad_in), .ui_in(ui_in),
    .uio_pad_in(uio_pad_in), .uio_pad_out(uio_pad_out), .uio_pad_oe(uio_pad_oe),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe),
    .core_rst_n(core_rst_n), .core_ena(core_ena)
  );

  always #5 clk = ~clk;

  // Model: count clean edges since rst_n release; pad history kept newest-first.
  int         n_edges = 0;
  logic [7:0] ui_q[$];
  logic [7:0] uio_q[$];
  logic [7:0] exp_out = 8'h00;
  logic [7:0] exp_oe  = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_edges = 0;
      ui_q.delete();
      uio_q.delete();
      exp_out = 8'h00;
      exp_oe  = 8'h00;
    end else begin
      exp_oe  = (n_edges >= HOLD + 3) ? uio_oe : 8'h00;
      exp_out = uio_out;
      ui_q.push_front(ui_pad_in);
      uio_q.push_front(uio_pad_in);
      if (ui_q.size() > SYNC) void'(ui_q.pop_back());
      if (uio_q.size() > SYNC) void'(uio_q.pop_back());
      if (n_edges < 100000) n_edges++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] e_ui, e_uio;
    logic       run;
    @(posedge clk);
    @(negedge clk);
    e_ui  = (ui_q.size()  >= SYNC) ? ui_q[SYNC-1]  : 8'h00;
    e_uio = (uio_q.size() >= SYNC) ? uio_q[SYNC-1] : 8'h00;
    run   = (n_edges >= HOLD + 3);
    check_val("ui_in",       {24'd0, ui_in},       {24'd0, e_ui});
    check_val("uio_in",      {24'd0, uio_in},      {24'd0, e_uio});
    check_val("uio_pad_out", {24'd0, uio_pad_out}, {24'd0, exp_out});
    check_val("uio_pad_oe",  {24'd0, uio_pad_oe},  {24'd0, exp_oe});
    check_val("core_rst_n",  {31'd0, core_rst_n},  {31'd0, run});
    check_val("core_ena",    {31'd0, core_ena},    {31'd0, run});
  endtask

  task automatic rand_in();
    ui_pad_in  = 8'($urandom);
    uio_pad_in = 8'($urandom);
    uio_out    = 8'($urandom);
    uio_oe     = 8'($urandom);
  endtask

  task automatic wait_release(input string tag, input int exp_edges);
    int k = 0;
    while (core_rst_n !== 1'b1 && k < 60) begin
      rand_in();
      tick();
      k++;
    end
    check_val(tag, k, exp_edges);
  endtask

  initial begin
    rst_n = 1'b0;
    ui_pad_in = 8'h00; uio_pad_in = 8'h00; uio_out = 8'h00; uio_oe = 8'hFF;

    repeat (5) begin
      ui_pad_in  = 8'($urandom);
      uio_pad_in = 8'($urandom);
      tick();
    end

    rst_n = 1'b1;
    wait_release("release_latency", HOLD + 3);

    ui_pad_in = 8'h00;
    repeat (3) tick();
    ui_pad_in = 8'hA5;
    tick();
    check_val("ui_one_edge", {24'd0, ui_in}, 32'h00);
    tick();
    check_val("ui_two_edges", {24'd0, ui_in}, 32'hA5);

    uio_oe = 8'h0F; uio_out = 8'h3C; uio_pad_in = 8'h9C;
    tick();
    check_val("oe_0f", {24'd0, uio_pad_oe}, 32'h0F);
    check_val("out_3c", {24'd0, uio_pad_out}, 32'h3C);
    tick();
    check_val("loopback_9c", {24'd0, uio_in}, 32'h9C);

    repeat (300) begin
      rand_in();
      tick();
    end

    // Glitch in the middle of HOLD: count is 10 after 13 edges.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (13) begin
      rand_in();
      tick();
    end
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    wait_release("glitch_latency", HOLD + 3);

    uio_oe = 8'hFF;
    tick();
    tick();
    check_val("run_oe_ff", {24'd0, uio_pad_oe}, 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_oe", {24'd0, uio_pad_oe}, 32'h00);
    check_val("async_rst", {31'd0, core_rst_n}, 32'd0);
    check_val("async_ena", {31'd0, core_ena}, 32'd0);
    tick();
    rst_n = 1'b1;
    wait_release("rerelease_latency", HOLD + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
